// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the 13-bit address / 8-bit data memory bus (ROM + RAM) between two
// requesters. Port 0 is the CPU fetch/data path and port 1 is the program
// loader / debug port. Each access runs as SETUP -> STROBE (WAIT_CYC+1
// cycles) -> HOLD. The block decodes the ROM/RAM chip enables and returns
// read data together with a one-cycle ack.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin arbitration between the two ports
//   undefined : fixed priority, port 0 over port 1
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req0/1, i_we0/1         request (held until ack), write enable
//   i_addr0/1, i_wdata0/1     access address and write data
//   o_gnt0/1                  port owns the bus (SETUP through HOLD)
//   o_ack0/1                  one-cycle completion pulse (HOLD cycle)
//   o_rdata                   read data, valid in the ack cycle and held
//   o_err                     pulses with ack: unmapped address or ROM write
//   o_busy                    sequencer not idle
//   o_mem_addr, o_mem_wdata   bus address and write data
//   i_mem_rdata               bus read data
//   o_mem_rd, o_mem_wr        read / write strobes
//   o_rom_en, o_ram_en        chip enables
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic              o_rom_en,
    output logic              o_ram_en
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    // Returns {ram_en, rom_en} for an address. The top two address bits
    // select RAM (11), an unmapped hole (01) or ROM (x0).
    function automatic logic [1:0] f_decode(input logic [ADDR_W-1:0] a);
        logic [1:0] d;
        case (a[ADDR_W-1 -: 2])
            2'b11:   d = 2'b10;
            2'b01:   d = 2'b00;
            default: d = 2'b01;
        endcase
        return d;
    endfunction

    state_t            r_state, w_state_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_we, w_we_nxt;
    logic [3:0]        r_wait_cnt, w_wait_cnt_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              w_sel1;
    logic [1:0]        w_dec_cur, w_dec_nxt;
    logic              w_bad_cur, w_bad_nxt;
    logic              w_active_nxt, w_strobe_nxt, w_hold_nxt;
    logic              r_gnt0, r_gnt1, r_ack0, r_ack1, r_err, r_busy;
    logic              r_mem_rd, r_mem_wr, r_rom_en, r_ram_en;

`ifdef MEM_ARB_RR_EN
    // r_rr_prio = 1 means port 1 wins the next simultaneous request.
    logic r_rr_prio, w_rr_prio_nxt;
    assign w_sel1 = i_req1 & (~i_req0 | r_rr_prio);

    // Round-robin pointer: after every grant, priority moves to the other port.
    always_comb begin
        w_rr_prio_nxt = r_rr_prio;
        if (r_state == ST_IDLE && (i_req0 | i_req1)) begin
            w_rr_prio_nxt = ~w_sel1;
        end else begin
            w_rr_prio_nxt = r_rr_prio;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_prio <= 1'b0;
        end else begin
            r_rr_prio <= w_rr_prio_nxt;
        end
    end
`else
    assign w_sel1 = i_req1 & ~i_req0;
`endif

    // A "bad" access (unmapped address, or a write to ROM) never strobes.
    assign w_dec_cur = f_decode(r_mem_addr);
    assign w_bad_cur = ~|w_dec_cur | (r_we & w_dec_cur[0]);
    assign w_dec_nxt = f_decode(w_addr_nxt);
    assign w_bad_nxt = ~|w_dec_nxt | (w_we_nxt & w_dec_nxt[0]);

    // Next-state logic, access latching and read-data capture.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_mem_addr;
        w_wdata_nxt    = r_mem_wdata;
        w_wait_cnt_nxt = r_wait_cnt;
        w_rdata_nxt    = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (i_req0 | i_req1) begin
                    w_state_nxt = ST_SETUP;
                    w_owner_nxt = w_sel1;
                    w_we_nxt    = w_sel1 ? i_we1    : i_we0;
                    w_addr_nxt  = w_sel1 ? i_addr1  : i_addr0;
                    w_wdata_nxt = w_sel1 ? i_wdata1 : i_wdata0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt    = ST_STROBE;
                w_wait_cnt_nxt = WAIT_LD;
            end
            ST_STROBE: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_HOLD;
                    // Capture data from the combinational memories on the last
                    // strobe cycle. Writes leave the last read value in place.
                    if (w_bad_cur) begin
                        w_rdata_nxt = {DATA_W{1'b0}};
                    end else if (!r_we) begin
                        w_rdata_nxt = i_mem_rdata;
                    end else begin
                        w_rdata_nxt = r_rdata;
                    end
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_active_nxt = (w_state_nxt != ST_IDLE);
    assign w_strobe_nxt = (w_state_nxt == ST_STROBE) & ~w_bad_nxt;
    assign w_hold_nxt   = (w_state_nxt == ST_HOLD);

    // FSM state and latched access registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_we        <= w_we_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
        end
    end

    // Registered bus controls, derived from the state being entered so
    // that they line up with it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_rom_en <= 1'b0;
            r_ram_en <= 1'b0;
        end else begin
            r_gnt0   <= w_active_nxt & ~w_owner_nxt;
            r_gnt1   <= w_active_nxt & w_owner_nxt;
            r_ack0   <= w_hold_nxt & ~w_owner_nxt;
            r_ack1   <= w_hold_nxt & w_owner_nxt;
            r_err    <= w_hold_nxt & w_bad_nxt;
            r_busy   <= w_active_nxt;
            r_mem_rd <= w_strobe_nxt & ~w_we_nxt;
            r_mem_wr <= w_strobe_nxt & w_we_nxt;
            r_rom_en <= w_active_nxt & w_dec_nxt[0];
            r_ram_en <= w_active_nxt & w_dec_nxt[1];
        end
    end

    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_rom_en    = r_rom_en;
    assign o_ram_en    = r_ram_en;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter. It contains a ROM/RAM environment
// and a transaction-level expectation model (access timeline, arbitration
// winner, memory contents). Two extra instances with WAIT_CYC = 0 and
// WAIT_CYC = 3 cover the latency boundaries.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int MW = 1;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [12:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1, err, busy;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [12:0] mem_addr;
    logic        mem_rd, mem_wr, rom_en, ram_en;
    logic [9:0]  obs_v;

    int total = 0;
    int bad   = 0;
    int prio  = 0;
    logic [7:0] rdata_m = 8'h00;
    logic [7:0] ram_model [0:2047] = '{default: 8'h00};
    logic [7:0] ram_mem   [0:2047] = '{default: 8'h00};

    function automatic logic [7:0] rom_val(input logic [12:0] a);
        return a[7:0] ^ 8'h39;
    endfunction

    mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(MW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_ack0(ack0), .o_ack1(ack1),
        .o_rdata(rdata), .o_err(err), .o_busy(busy),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_rom_en(rom_en), .o_ram_en(ram_en)
    );

    assign obs_v = {gnt0, gnt1, ack0, ack1, err, busy, mem_rd, mem_wr, rom_en, ram_en};
    assign mem_rdata = ram_en ? ram_mem[mem_addr[10:0]] : (rom_en ? rom_val(mem_addr) : 8'hFF);

    always @(posedge clk) begin
        if (mem_wr && ram_en) ram_mem[mem_addr[10:0]] <= mem_wdata;
    end

    // Latency-boundary instances: port 0 read only.
    logic        a_req_w0, a_req_w3;
    logic        w0_gnt0, w0_gnt1, w0_ack0, w0_ack1, w0_err, w0_busy, w0_rd, w0_wr, w0_rom, w0_ram;
    logic        w3_gnt0, w3_gnt1, w3_ack0, w3_ack1, w3_err, w3_busy, w3_rd, w3_wr, w3_rom, w3_ram;
    logic [7:0]  w0_rdata, w0_wdata, w0_mrdata, w3_rdata, w3_wdata, w3_mrdata;
    logic [12:0] w0_addr, w3_addr;

    assign w0_mrdata = w0_rom ? rom_val(w0_addr) : 8'h00;
    assign w3_mrdata = w3_rom ? rom_val(w3_addr) : 8'h00;

    mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(0)) u_w0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(a_req_w0), .i_req1(1'b0), .i_we0(1'b0), .i_we1(1'b0),
        .i_addr0(13'h0005), .i_addr1(13'h0000), .i_wdata0(8'h00), .i_wdata1(8'h00),
        .o_gnt0(w0_gnt0), .o_gnt1(w0_gnt1), .o_ack0(w0_ack0), .o_ack1(w0_ack1),
        .o_rdata(w0_rdata), .o_err(w0_err), .o_busy(w0_busy),
        .o_mem_addr(w0_addr), .o_mem_wdata(w0_wdata), .i_mem_rdata(w0_mrdata),
        .o_mem_rd(w0_rd), .o_mem_wr(w0_wr), .o_rom_en(w0_rom), .o_ram_en(w0_ram)
    );

    mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(3)) u_w3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(a_req_w3), .i_req1(1'b0), .i_we0(1'b0), .i_we1(1'b0),
        .i_addr0(13'h0005), .i_addr1(13'h0000), .i_wdata0(8'h00), .i_wdata1(8'h00),
        .o_gnt0(w3_gnt0), .o_gnt1(w3_gnt1), .o_ack0(w3_ack0), .o_ack1(w3_ack1),
        .o_rdata(w3_rdata), .o_err(w3_err), .o_busy(w3_busy),
        .o_mem_addr(w3_addr), .o_mem_wdata(w3_wdata), .i_mem_rdata(w3_mrdata),
        .o_mem_rd(w3_rd), .o_mem_wr(w3_wr), .o_rom_en(w3_rom), .o_ram_en(w3_ram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected control vector for timeline cycle c of an access. Cycle 1 is
    // the idle cycle in which the request is seen. The ack arrives in cycle
    // MW+4.
    function automatic logic [9:0] exp_vec(input int c, input int p, input logic we, input logic [12:0] a);
        logic rom, ram, bacc, act, stb, hold;
        rom  = (a[11] == 1'b0);
        ram  = (a[12:11] == 2'b11);
        bacc = !(rom || ram) || (we && rom);
        act  = (c >= 2);
        stb  = (c >= 3) && (c <= MW + 3);
        hold = (c == MW + 4);
        return {act && p == 0, act && p == 1, hold && p == 0, hold && p == 1, hold && bacc,
                act, stb && !we && !bacc, stb && we && !bacc, act && rom, act && ram};
    endfunction

    function automatic int both_winner();
`ifdef MEM_ARB_RR_EN
        return prio;
`else
        return 0;
`endif
    endfunction

    function automatic logic [12:0] rnd_addr();
        case ($urandom_range(3, 0))
            0:       return {2'b11, 7'd0, 4'($urandom_range(15, 0))};
            1:       return 13'($urandom_range(2047, 0));
            2:       return 13'h1000 | 13'($urandom_range(2047, 0));
            default: return 13'h0800 | 13'($urandom_range(2047, 0));
        endcase
    endfunction

    task automatic drive(input int p, input logic we, input logic [12:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Checks cycles 2..MW+4 of an access already granted to port p, then
    // drops that port's request at the ack.
    task automatic do_access(input int p, input logic we, input logic [12:0] a, input logic [7:0] d, input string tag);
        logic rom, ram, bacc;
        rom  = (a[11] == 1'b0);
        ram  = (a[12:11] == 2'b11);
        bacc = !(rom || ram) || (we && rom);
        prio = 1 - p;
        for (int c = 2; c <= MW + 4; c++) begin
            @(negedge clk);
            chk({tag, "_ctl"}, 32'(obs_v), 32'(exp_vec(c, p, we, a)));
            chk({tag, "_bus"}, 32'({mem_addr, mem_wdata}), 32'({a, d}));
            if (c == MW + 4) begin
                if (bacc) rdata_m = 8'h00;
                else if (!we) rdata_m = ram ? ram_model[a[10:0]] : rom_val(a);
                else if (ram) ram_model[a[10:0]] = d;
                chk({tag, "_rdata"}, 32'(rdata), 32'(rdata_m));
                if (p == 0) req0 = 1'b0; else req1 = 1'b0;
            end
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [12:0] a, input logic [7:0] d, input string tag);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(obs_v), 32'd0);
        drive(p, we, a, d);
        do_access(p, we, a, d, tag);
    endtask

    initial begin
        int ackc0, ackc3, wid0, wid3;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 13'h0; addr1 = 13'h0; wdata0 = 8'h0; wdata1 = 8'h0;
        a_req_w0 = 1'b0; a_req_w3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'(obs_v), 32'd0);
        chk("reset_bus", 32'({mem_addr, mem_wdata, rdata}), 32'd0);
        rst_n = 1'b1;

        // ROM read of 0x0005 on port 0.
        issue(0, 1'b0, 13'h0005, 8'h00, "t1");
        // RAM write on port 1.
        issue(1, 1'b1, 13'h1802, 8'hA5, "t2");
        chk("t2_ram_cell", 32'(ram_mem[2]), 32'h0000_00A5);
        issue(1, 1'b0, 13'h1802, 8'h00, "t2rb");

        // Both ports hold read requests for four accesses.
        @(negedge clk);
        chk("t3_idle", 32'(obs_v), 32'd0);
        drive(0, 1'b0, 13'h0003, 8'h00);
        drive(1, 1'b0, 13'h0004, 8'h00);
        for (int k = 0; k < 4; k++) begin
            int w;
            bit found;
            w = both_winner();
            prio = 1 - w;
            found = 1'b0;
            for (int n = 0; n < 12 && !found; n++) begin
                @(negedge clk);
                if (ack0 || ack1) found = 1'b1;
            end
            chk("t3_ack_port", 32'({ack0, ack1}), (w == 0) ? 32'd2 : 32'd1);
            rdata_m = rom_val((w == 0) ? 13'h0003 : 13'h0004);
            chk("t3_rdata", 32'(rdata), 32'(rdata_m));
        end
        req0 = 1'b0; req1 = 1'b0;

        // Unmapped read, then a write to ROM.
        issue(0, 1'b0, 13'h0800, 8'h00, "t4r");
        issue(0, 1'b1, 13'h0010, 8'h55, "t4w");

        // Reset in the middle of a write strobe.
        @(negedge clk);
        drive(0, 1'b1, 13'h1FFF, 8'h77);
        @(negedge clk);
        @(negedge clk);
        chk("t5_strobe", 32'(obs_v), 32'(exp_vec(3, 0, 1'b1, 13'h1FFF)));
        rst_n = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("t5_rst_ctl", 32'(obs_v), 32'd0);
        chk("t5_rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prio = 0;
        rdata_m = 8'h00;
        issue(0, 1'b0, 13'h0005, 8'h00, "t5post");

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int mode, w, l;
            logic [12:0] a0, a1;
            logic [7:0] d0, d1;
            logic e0, e1;
            mode = $urandom_range(2, 0);
            a0 = rnd_addr(); a1 = rnd_addr();
            d0 = 8'($urandom); d1 = 8'($urandom);
            e0 = 1'($urandom_range(1, 0)); e1 = 1'($urandom_range(1, 0));
            @(negedge clk);
            chk("rnd_idle", 32'(obs_v), 32'd0);
            if (mode != 1) drive(0, e0, a0, d0);
            if (mode != 0) drive(1, e1, a1, d1);
            w = (mode == 2) ? both_winner() : ((mode == 1) ? 1 : 0);
            if (w == 0) do_access(0, e0, a0, d0, "rnd_a");
            else        do_access(1, e1, a1, d1, "rnd_a");
            if (mode == 2) begin
                l = 1 - w;
                @(negedge clk);
                chk("rnd_gap", 32'(obs_v), 32'd0);
                if (l == 0) do_access(0, e0, a0, d0, "rnd_b");
                else        do_access(1, e1, a1, d1, "rnd_b");
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        // Latency boundaries: WAIT_CYC = 0 and WAIT_CYC = 3.
        @(negedge clk);
        a_req_w0 = 1'b1; a_req_w3 = 1'b1;
        ackc0 = 0; ackc3 = 0; wid0 = 0; wid3 = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("t6_w0_setup", 32'({w0_addr, w0_wdata, w0_gnt0, w0_gnt1, w0_rom, w0_ram}), 32'({13'h0005, 8'h00, 4'b1010}));
                chk("t6_w3_setup", 32'({w3_addr, w3_wdata, w3_gnt0, w3_gnt1, w3_rom, w3_ram}), 32'({13'h0005, 8'h00, 4'b1010}));
            end
            if (w0_rd) wid0++;
            if (w3_rd) wid3++;
            if (w0_ack0 && ackc0 == 0) begin
                ackc0 = c;
                chk("t6_w0_rdata", 32'({w0_rdata, w0_err}), 32'({8'h3C, 1'b0}));
                a_req_w0 = 1'b0;
            end
            if (w3_ack0 && ackc3 == 0) begin
                ackc3 = c;
                chk("t6_w3_rdata", 32'({w3_rdata, w3_err}), 32'({8'h3C, 1'b0}));
                a_req_w3 = 1'b0;
            end
        end
        chk("t6_w0_latency", 32'(ackc0), 32'd4);
        chk("t6_w0_width", 32'(wid0), 32'd1);
        chk("t6_w3_latency", 32'(ackc3), 32'd7);
        chk("t6_w3_width", 32'(wid3), 32'd4);
        chk("t6_idle", 32'({w0_busy, w0_wr, w0_ack1, w3_busy, w3_wr, w3_ack1}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
